instruction_encoder: RTL

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_pkg.sv | 71 +++++++
 rtl/instruction_encoder_fifo.sv | 64 ++++++
 rtl/instruction_encoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/instruction_pkg.sv
// Shared instruction field layout for the encoder and the decoder.
// Holds field widths, format codes, the field bundle type, and the
// word encode/decode functions, so both directions use one bit layout.
package instruction_pkg;

  localparam int INSTR_W = 20;
  localparam int OP_W    = 6;
  localparam int REG_W   = 2;
  localparam int SMIMM_W = 10;
  localparam int BGIMM_W = 12;
  localparam int JUMP_W  = 11;
  localparam int IMEM_W  = 11;

  localparam logic [1:0] FMT_RRR = 2'd0;
  localparam logic [1:0] FMT_RRI = 2'd1;
  localparam logic [1:0] FMT_RI  = 2'd2;
  localparam logic [1:0] FMT_J   = 2'd3;

  // Zero padding at the LSB end of the short formats
  localparam int RRR_PAD = INSTR_W - OP_W - 3 * REG_W;
  localparam int J_PAD   = INSTR_W - OP_W - JUMP_W;

  typedef logic [INSTR_W-1:0] instrWord_t;

  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rAlpha;
    logic [REG_W-1:0]   rBeta;
    logic [REG_W-1:0]   rGamma;
    logic [SMIMM_W-1:0] smImm;
    logic [BGIMM_W-1:0] bgImm;
    logic [JUMP_W-1:0]  jumpAddress;
  } instrFields_t;

  function automatic instrWord_t encodeWord(input logic [1:0] fmt, input instrFields_t f);
    instrWord_t w;
    case (fmt)
      FMT_RRR: w = {f.opcode, f.rAlpha, f.rBeta, f.rGamma, {RRR_PAD{1'b0}}};
      FMT_RRI: w = {f.opcode, f.rAlpha, f.rBeta, f.smImm};
      FMT_RI:  w = {f.opcode, f.rAlpha, f.bgImm};
      default: w = {f.opcode, f.jumpAddress, {J_PAD{1'b0}}};
    endcase
    return w;
  endfunction

  // Fields not carried by the given format come back as zero.
  function automatic instrFields_t decodeWord(input logic [1:0] fmt, input instrWord_t w);
    instrFields_t f;
    f = '0;
    f.opcode = w[INSTR_W-1 -: OP_W];
    case (fmt)
      FMT_RRR: begin
        f.rAlpha = w[INSTR_W-OP_W-1 -: REG_W];
        f.rBeta  = w[INSTR_W-OP_W-REG_W-1 -: REG_W];
        f.rGamma = w[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
      end
      FMT_RRI: begin
        f.rAlpha = w[INSTR_W-OP_W-1 -: REG_W];
        f.rBeta  = w[INSTR_W-OP_W-REG_W-1 -: REG_W];
        f.smImm  = w[SMIMM_W-1:0];
      end
      FMT_RI: begin
        f.rAlpha = w[INSTR_W-OP_W-1 -: REG_W];
        f.bgImm  = w[BGIMM_W-1:0];
      end
      default: f.jumpAddress = w[INSTR_W-OP_W-1 -: JUMP_W];
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instruction_encoder_fifo.sv
// encoder_fifo: synchronous staging FIFO for encoded instruction words.
// Ports: clk, reset (async, active-high, clears pointers/count only),
//   push/pushData (write, ignored when full), pop/popData (head word,
//   pop ignored when empty), full, empty, count (words held).
// DEPTH must be a power of two so the pointers wrap naturally.
module encoder_fifo
  import instruction_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          pushData,
  input  logic                       pop,
  output logic [DATA_W-1:0]          popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    cnt;
  logic              doPush;
  logic              doPop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign popData = store[rdPtr];
  // Full is judged on the pre-pop count: a push into a full FIFO is refused
  // even when a pop happens on the same edge.
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes instruction fields into words and streams
// them into instruction memory through a small staging FIFO.
// Ports: clk, reset (async, active-high); start/base_addr open a session;
//   in_valid/in_ready/in_last + format/opcode/rAlpha/rBeta/rGamma/smImm/
//   bgImm/jumpAddress are the field input handshake; mem_we/mem_ready/
//   mem_addr/mem_wdata are the memory write handshake; busy, done (pulse),
//   overflow (sticky) and word_count report session status.
module instruction_encoder
  import instruction_pkg::*;
#(
  parameter int INSTRUCTION_SIZE     = INSTR_W,
  parameter int OP_SIZE              = OP_W,
  parameter int REG_ADDRESS_SIZE     = REG_W,
  parameter int SMALL_IMMEDIATE_SIZE = SMIMM_W,
  parameter int BIG_IMMEDIATE_SIZE   = BGIMM_W,
  parameter int JUMP_ADDRESS_SIZE    = JUMP_W,
  parameter int IMEM_ADDRESS_SIZE    = IMEM_W,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [IMEM_ADDRESS_SIZE-1:0]    base_addr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [1:0]                      format,
  input  logic [OP_SIZE-1:0]              opcode,
  input  logic [REG_ADDRESS_SIZE-1:0]     rAlpha,
  input  logic [REG_ADDRESS_SIZE-1:0]     rBeta,
  input  logic [REG_ADDRESS_SIZE-1:0]     rGamma,
  input  logic [SMALL_IMMEDIATE_SIZE-1:0] smImm,
  input  logic [BIG_IMMEDIATE_SIZE-1:0]   bgImm,
  input  logic [JUMP_ADDRESS_SIZE-1:0]    jumpAddress,
  output logic                            mem_we,
  input  logic                            mem_ready,
  output logic [IMEM_ADDRESS_SIZE-1:0]    mem_addr,
  output logic [INSTRUCTION_SIZE-1:0]     mem_wdata,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [IMEM_ADDRESS_SIZE:0]      word_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]             FIFO_ONE = 1;
  localparam logic [IMEM_ADDRESS_SIZE-1:0] ADDR_ONE = 1;
  localparam logic [IMEM_ADDRESS_SIZE-1:0] ADDR_MAX = '1;
  localparam logic [IMEM_ADDRESS_SIZE:0]   WC_ONE   = 1;

  logic [1:0]                      state;
  logic [IMEM_ADDRESS_SIZE-1:0]    addrCnt;
  logic [IMEM_ADDRESS_SIZE:0]      wordCnt;
  logic                            overflowFlag;
  logic                            exhausted;   // last memory address already written

  logic                            fifoFull;
  logic                            fifoEmpty;
  logic [CNT_W-1:0]                fifoCount;
  logic [INSTRUCTION_SIZE-1:0]     fifoHead;
  logic [INSTRUCTION_SIZE-1:0]     encoded;
  instrFields_t                    fields;

  logic draining;
  logic accept;
  logic pop;
  logic writeDone;
  logic discard;
  logic lastOut;

  assign fields = '{opcode: opcode, rAlpha: rAlpha, rBeta: rBeta, rGamma: rGamma,
                    smImm: smImm, bgImm: bgImm, jumpAddress: jumpAddress};
  assign encoded = encodeWord(format, fields);

  assign draining  = (state == ACTIVE) || (state == FLUSH);
  assign in_ready  = (state == ACTIVE) & ~fifoFull;
  assign accept    = in_valid & in_ready;
  assign mem_we    = draining & ~fifoEmpty & ~exhausted;
  // Once memory is exhausted the head is dropped every cycle without
  // waiting on mem_ready, so the session still drains and finishes.
  assign pop       = draining & ~fifoEmpty & (exhausted | mem_ready);
  assign writeDone = mem_we & mem_ready;
  assign discard   = pop & exhausted;
  assign lastOut   = pop & (fifoCount == FIFO_ONE);

  assign mem_addr   = addrCnt;
  assign mem_wdata  = fifoHead;
  assign busy       = draining;
  assign done       = (state == DONE);
  assign overflow   = overflowFlag;
  assign word_count = wordCnt;

  encoder_fifo #(
    .DATA_W (INSTRUCTION_SIZE),
    .DEPTH  (FIFO_DEPTH)
  ) stageFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .pushData (encoded),
    .pop      (pop),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addrCnt      <= '0;
      wordCnt      <= '0;
      overflowFlag <= 1'b0;
      exhausted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ACTIVE;
            addrCnt      <= base_addr;
            wordCnt      <= '0;
            overflowFlag <= 1'b0;
            exhausted    <= 1'b0;
          end
        end
        ACTIVE: if (accept && in_last) state <= FLUSH;
        FLUSH:  if (fifoEmpty || lastOut) state <= DONE;
        default: state <= IDLE;
      endcase

      // Writes only occur while draining, so they never collide with the
      // session-start load above.
      if (writeDone) begin
        wordCnt <= wordCnt + WC_ONE;
        if (addrCnt == ADDR_MAX) exhausted <= 1'b1;
        else                     addrCnt   <= addrCnt + ADDR_ONE;
      end
      if (discard) overflowFlag <= 1'b1;
    end
  end

endmodule
